// File: rtl/load_wb_pkg.sv
// Shared types and constants for the load/writeback unit: opcode classes,
// load funct3 codes, FSM states and the access-size helper.
package load_wb_pkg;

    // instr_opcode[5]: 0 selects an ALU op; otherwise [4:3] selects the class
    localparam logic       OPC_ALU    = 1'b0;
    localparam logic [1:0] OPC_LOAD   = 2'b00;
    localparam logic [1:0] OPC_STORE  = 2'b01;
    localparam logic [1:0] OPC_BRANCH = 2'b10;
    localparam logic [1:0] OPC_JUMP   = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ0,
        ST_REQ1,
        ST_WB
    } state_t;

    // Bytes touched by a load; 0 for an unused encoding.
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return 4'd1;
            F3_LH, F3_LHU: return 4'd2;
            F3_LW, F3_LWU: return 4'd4;
            F3_LD:         return 4'd8;
            default:       return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_wb_unit_if.sv
// Instruction handshake, data-memory read port and register-file write port
// of the load/writeback unit, bundled as one interface.
interface load_wb_unit_if #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [5:0]           instr_opcode_i;
    logic [XLEN-1:0]      alu_out_i;
    logic [RF_ADDR_W-1:0] rd_i;
    logic                 dmem_req_o;
    logic [XLEN-1:0]      dmem_addr_o;
    logic                 dmem_rvalid_i;
    logic [XLEN-1:0]      dmem_rdata_i;
    logic                 rf_we_o;
    logic [RF_ADDR_W-1:0] rf_waddr_o;
    logic [XLEN-1:0]      rf_write_o;
    logic                 misalign_o;
    logic                 illegal_o;

    modport slave (
        input  in_valid_i, instr_opcode_i, alu_out_i, rd_i, dmem_rvalid_i, dmem_rdata_i,
        output in_ready_o, dmem_req_o, dmem_addr_o, rf_we_o, rf_waddr_o, rf_write_o,
               misalign_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_opcode_i, alu_out_i, rd_i, dmem_rvalid_i, dmem_rdata_i,
        input  in_ready_o, dmem_req_o, dmem_addr_o, rf_we_o, rf_waddr_o, rf_write_o,
               misalign_o, illegal_o
    );
endinterface

// File: rtl/load_wb_unit_extract.sv
// Combinational load aligner: shifts a two-word window down by the byte
// offset, then sign- or zero-extends the selected width to XLEN.
module load_extract
    import load_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          window,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            value,
    output logic                       legal
);
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   low;
    logic [3:0]        nbytes;
    logic [6:0]        nbits;
    logic              sign_bit;
    logic              fill;

    assign shifted = window >> {offset, 3'b000};
    assign low     = shifted[XLEN-1:0];
    assign nbytes  = access_bytes(funct3);
    assign nbits   = {nbytes, 3'b000};

    always_comb begin
        case (nbytes)
            4'd1:    sign_bit = low[7];
            4'd2:    sign_bit = low[15];
            4'd4:    sign_bit = low[31];
            default: sign_bit = low[XLEN-1];
        endcase
    end

    // funct3[2] marks the zero-extending variants
    assign fill = sign_bit & ~funct3[2];

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
        assign value[gi] = (7'(gi) < nbits) ? low[gi] : fill;
    end

    always_comb begin
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
            F3_LD, F3_LWU:                       legal = (XLEN == 64);
            default:                             legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/load_wb_unit.sv
// Writeback stage: forwards ALU results or fetches, aligns and extends load
// data (splitting a line-crossing load into two beats) before one RF write.
module load_wb_unit
    import load_wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MISALIGN_EN = 1,
    parameter int RF_ADDR_W   = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    load_wb_unit_if.slave  bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t               state_reg, state_next;
    logic [2:0]           funct3_reg, funct3_next;
    logic [RF_ADDR_W-1:0] rd_reg, rd_next;
    logic [XLEN-1:0]      addr_reg, addr_next;
    logic [XLEN-1:0]      beat0_reg, beat0_next;
    logic                 rf_we_reg, rf_we_next;
    logic [RF_ADDR_W-1:0] rf_waddr_reg, rf_waddr_next;
    logic [XLEN-1:0]      rf_write_reg, rf_write_next;
    logic                 misalign_reg, misalign_next;
    logic                 illegal_reg, illegal_next;

    logic                 is_load, writes_alu;
    logic [OFF_W-1:0]     offset;
    logic [4:0]           end_byte;
    logic                 spill;
    logic [XLEN-1:0]      aligned;
    logic [2*XLEN-1:0]    ext_window;
    logic [2:0]           ext_funct3;
    logic [XLEN-1:0]      ext_value;
    logic                 ext_legal;
    logic                 do_write;
    logic [XLEN-1:0]      write_val;
    logic [RF_ADDR_W-1:0] wr_rd;
    logic                 req;

    assign is_load    = (bus.instr_opcode_i[5] != OPC_ALU) && (bus.instr_opcode_i[4:3] == OPC_LOAD);
    assign writes_alu = (bus.instr_opcode_i[5] == OPC_ALU) || (bus.instr_opcode_i[4:3] == OPC_JUMP);

    assign offset   = addr_reg[OFF_W-1:0];
    assign end_byte = 5'(offset) + 5'(access_bytes(funct3_reg));
    assign spill    = end_byte > 5'(NB);
    assign aligned  = {addr_reg[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    // Legality is judged on the incoming funct3 while idle, on the captured one afterwards
    assign ext_funct3 = (state_reg == ST_IDLE) ? bus.instr_opcode_i[2:0] : funct3_reg;
    assign ext_window = (state_reg == ST_REQ1) ? {bus.dmem_rdata_i, beat0_reg}
                                               : {{XLEN{1'b0}}, bus.dmem_rdata_i};

    load_extract #(.XLEN(XLEN)) u_extract (
        .window (ext_window),
        .offset (offset),
        .funct3 (ext_funct3),
        .value  (ext_value),
        .legal  (ext_legal)
    );

    always_comb begin
        state_next  = state_reg;
        funct3_next = funct3_reg;
        rd_next     = rd_reg;
        addr_next   = addr_reg;
        beat0_next  = beat0_reg;
        misalign_next = 1'b0;
        illegal_next  = 1'b0;
        do_write    = 1'b0;
        write_val   = '0;
        wr_rd       = rd_reg;
        case (state_reg)
            ST_IDLE: begin
                wr_rd = bus.rd_i;
                if (bus.in_valid_i) begin
                    funct3_next = bus.instr_opcode_i[2:0];
                    rd_next     = bus.rd_i;
                    addr_next   = bus.alu_out_i;
                    state_next  = ST_WB;
                    if (is_load) begin
                        if (ext_legal) state_next   = ST_REQ0;
                        else           illegal_next = 1'b1;
                    end else if (writes_alu) begin
                        do_write  = 1'b1;
                        write_val = bus.alu_out_i;
                    end
                end
            end
            ST_REQ0: begin
                if (bus.dmem_rvalid_i) begin
                    if (!spill) begin
                        do_write   = 1'b1;
                        write_val  = ext_value;
                        state_next = ST_WB;
                    end else if (MISALIGN_EN != 0) begin
                        beat0_next = bus.dmem_rdata_i;
                        state_next = ST_REQ1;
                    end else begin
                        misalign_next = 1'b1;
                        state_next    = ST_WB;
                    end
                end
            end
            ST_REQ1: begin
                if (bus.dmem_rvalid_i) begin
                    do_write   = 1'b1;
                    write_val  = ext_value;
                    state_next = ST_WB;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Results are registered on entry to WB, so the pulse coincides with WB
        rf_we_next    = do_write && (wr_rd != '0);
        rf_waddr_next = rf_we_next ? wr_rd : rf_waddr_reg;
        rf_write_next = rf_we_next ? write_val : rf_write_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            funct3_reg   <= '0;
            rd_reg       <= '0;
            addr_reg     <= '0;
            beat0_reg    <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_write_reg <= '0;
            misalign_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            funct3_reg   <= funct3_next;
            rd_reg       <= rd_next;
            addr_reg     <= addr_next;
            beat0_reg    <= beat0_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_write_reg <= rf_write_next;
            misalign_reg <= misalign_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign req = ((state_reg == ST_REQ0) || (state_reg == ST_REQ1)) && !rst_i;

    assign bus.in_ready_o  = (state_reg == ST_IDLE) && !rst_i;
    assign bus.dmem_req_o  = req;
    assign bus.dmem_addr_o = !req ? '0 : (state_reg == ST_REQ1) ? aligned + XLEN'(NB) : aligned;
    assign bus.rf_we_o     = rf_we_reg;
    assign bus.rf_waddr_o  = rf_waddr_reg;
    assign bus.rf_write_o  = rf_write_reg;
    assign bus.misalign_o  = misalign_reg;
    assign bus.illegal_o   = illegal_reg;
endmodule

// File: tb/tb_load_wb_unit.sv
// Bench for load_wb_unit: three instances (32-bit split, 32-bit no-split,
// 64-bit split) checked against a byte-level memory and load-semantics model.
module tb_load_wb_unit;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid [N];
    logic [5:0]  opc      [N];
    logic [63:0] alu      [N];
    logic [4:0]  rd       [N];
    logic        stall    [N];
    logic        late     [N];

    logic        in_ready [N];
    logic        req      [N];
    logic        we       [N];
    logic        mis      [N];
    logic        ill      [N];
    logic        rv       [N];
    logic [63:0] daddr    [N];
    logic [63:0] wdata    [N];
    logic [4:0]  waddr    [N];

    logic [7:0]  mem [2048];

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] mem_word(input logic [63:0] a, input int nb);
        logic [63:0] w = '0;
        for (int i = 0; i < nb; i++)
            w = w | (64'(mem[(int'(a[10:0]) + i) % 2048]) << (8 * i));
        return w;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int XL = (gi == 2) ? 64 : 32;
        localparam int ME = (gi == 1) ? 0 : 1;
        logic        rvalid_l = 1'b0;
        logic [63:0] rdata_l  = '0;
        int          cnt      = 0;

        load_wb_unit_if #(.XLEN(XL), .RF_ADDR_W(5)) bus ();

        assign bus.in_valid_i     = in_valid[gi];
        assign bus.instr_opcode_i = opc[gi];
        assign bus.alu_out_i      = alu[gi][XL-1:0];
        assign bus.rd_i           = rd[gi];
        assign bus.dmem_rvalid_i  = rvalid_l;
        assign bus.dmem_rdata_i   = rdata_l[XL-1:0];
        assign in_ready[gi] = bus.in_ready_o;
        assign req[gi]      = bus.dmem_req_o;
        assign daddr[gi]    = 64'(bus.dmem_addr_o);
        assign we[gi]       = bus.rf_we_o;
        assign waddr[gi]    = bus.rf_waddr_o;
        assign wdata[gi]    = 64'(bus.rf_write_o);
        assign mis[gi]      = bus.misalign_o;
        assign ill[gi]      = bus.illegal_o;
        assign rv[gi]       = rvalid_l;

        load_wb_unit #(.XLEN(XL), .MISALIGN_EN(ME), .RF_ADDR_W(5)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );

        // Memory responder: one-cycle rvalid after 0..2 idle cycles of request
        initial forever begin
            @(negedge clk);
            if (rvalid_l) begin
                rvalid_l = 1'b0;
            end else if (late[gi]) begin
                rvalid_l = 1'b1;
                rdata_l  = {$urandom, $urandom};
            end else if (bus.dmem_req_o && !stall[gi]) begin
                if (cnt == 0) begin
                    rvalid_l = 1'b1;
                    rdata_l  = mem_word(64'(bus.dmem_addr_o), XL / 8);
                    cnt      = $urandom_range(0, 2);
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [63:0] w, input int nb);
        for (int i = 0; i < nb; i++) mem[a + i] = w[8*i +: 8];
    endtask

    // Reference behaviour derived from load semantics over a byte memory
    task automatic model(input int k, input logic [5:0] op, input logic [63:0] a,
                         input logic [4:0] r, output logic we_o, output logic [63:0] data_o,
                         output logic mis_o, output logic ill_o, output int beats_o,
                         output logic [63:0] a0, output logic [63:0] a1);
        int          xl    = (k == 2) ? 64 : 32;
        int          nb    = xl / 8;
        bit          me    = (k != 1);
        int          size  = 0;
        int          off;
        bit          sgn;
        logic [63:0] v     = '0;
        logic [63:0] xmask = (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        we_o = 1'b0; data_o = '0; mis_o = 1'b0; ill_o = 1'b0; beats_o = 0; a0 = '0; a1 = '0;
        if (!op[5] || op[4:3] == 2'b11) begin
            we_o   = (r != 0);
            data_o = a & xmask;
        end else if (op[4:3] == 2'b00) begin
            case (op[2:0])
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                3'd6:       size = (xl == 64) ? 4 : 0;
                3'd3:       size = (xl == 64) ? 8 : 0;
                default:    size = 0;
            endcase
            sgn = !op[2];
            if (size == 0) begin
                ill_o = 1'b1;
            end else begin
                off = int'(a[2:0]) % nb;
                a0  = a - 64'(off);
                a1  = a0 + 64'(nb);
                if (off + size > nb && !me) begin
                    mis_o   = 1'b1;
                    beats_o = 1;
                end else begin
                    beats_o = (off + size > nb) ? 2 : 1;
                    for (int i = 0; i < size; i++)
                        v = v | (64'(mem[int'(a[10:0]) + i]) << (8 * i));
                    if (sgn && size < 8 && v[8*size-1])
                        v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
                    data_o = v & xmask;
                    we_o   = (r != 0);
                end
            end
        end
    endtask

    task automatic run_op(input int k, input logic [5:0] op, input logic [63:0] a, input logic [4:0] r);
        logic        e_we, e_mis, e_ill;
        logic [63:0] e_data, e_a0, e_a1;
        int          e_beats;
        int          beats = 0, wes = 0, miss = 0, ills = 0, busy = 0;
        logic [63:0] got_data = '0, addr0 = '0, addr1 = '0;
        logic [4:0]  got_waddr = '0;
        bit          done = 1'b0;
        model(k, op, a, r, e_we, e_data, e_mis, e_ill, e_beats, e_a0, e_a1);
        tick();
        check($sformatf("ready_k%0d", k), 64'(in_ready[k]), 64'd1);
        in_valid[k] = 1'b1;
        opc[k] = op;
        alu[k] = a;
        rd[k]  = r;
        tick();
        in_valid[k] = 1'b0;
        alu[k] = {$urandom, $urandom};
        rd[k]  = 5'($urandom);
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) tick();
            if (in_ready[k]) begin
                done = 1'b1;
            end else begin
                busy++;
                if (req[k] && rv[k]) begin
                    if (beats == 0) addr0 = daddr[k];
                    else            addr1 = daddr[k];
                    beats++;
                end
                if (we[k]) begin
                    wes++;
                    got_data  = wdata[k];
                    got_waddr = waddr[k];
                end
                if (mis[k]) miss++;
                if (ill[k]) ills++;
            end
        end
        $display("op k=%0d opc=%b addr=%h rd=%0d beats=%0d we=%0d data=%h mis=%0d ill=%0d",
                 k, op, a, r, beats, wes, got_data, miss, ills);
        check($sformatf("done_k%0d", k), 64'(done), 64'd1);
        check($sformatf("we_cnt_k%0d", k), 64'(wes), 64'(e_we));
        check($sformatf("mis_cnt_k%0d", k), 64'(miss), 64'(e_mis));
        check($sformatf("ill_cnt_k%0d", k), 64'(ills), 64'(e_ill));
        check($sformatf("beats_k%0d", k), 64'(beats), 64'(e_beats));
        if (e_we) begin
            check($sformatf("wdata_k%0d", k), got_data, e_data);
            check($sformatf("waddr_k%0d", k), 64'(got_waddr), 64'(r));
        end
        if (e_beats > 0) check($sformatf("addr0_k%0d", k), addr0, e_a0);
        if (e_beats == 2) check($sformatf("addr1_k%0d", k), addr1, e_a1);
        if (e_beats == 0) check($sformatf("busy_k%0d", k), 64'(busy), 64'd1);
    endtask

    initial begin
        bit          seen;
        int          wes;
        int          cls;
        logic [5:0]  rop;
        logic [63:0] ra;
        for (int k = 0; k < N; k++) begin
            in_valid[k] = 1'b0; opc[k] = '0; alu[k] = '0; rd[k] = '0;
            stall[k] = 1'b0; late[k] = 1'b0;
        end
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_ready_k%0d", k), 64'(in_ready[k]), 64'd0);
            check($sformatf("rst_req_k%0d", k), 64'(req[k]), 64'd0);
            check($sformatf("rst_addr_k%0d", k), daddr[k], 64'd0);
            check($sformatf("rst_we_k%0d", k), 64'(we[k]), 64'd0);
            check($sformatf("rst_waddr_k%0d", k), 64'(waddr[k]), 64'd0);
            check($sformatf("rst_wdata_k%0d", k), wdata[k], 64'd0);
            check($sformatf("rst_mis_k%0d", k), 64'(mis[k]), 64'd0);
            check($sformatf("rst_ill_k%0d", k), 64'(ill[k]), 64'd0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < N; k++)
            check($sformatf("post_rst_ready_k%0d", k), 64'(in_ready[k]), 64'd1);

        // Directed cases
        run_op(0, 6'b000000, 64'hDEAD_BEEF, 5'd5);
        run_op(0, 6'b111000, 64'h1234_5678, 5'd9);
        poke(32'h100, 64'h80FF_1234, 4);
        run_op(0, 6'b100000, 64'h103, 5'd3);
        run_op(0, 6'b100100, 64'h103, 5'd3);
        poke(32'h100, 64'hAABB_1122, 4);
        poke(32'h104, 64'h3344_5566, 4);
        run_op(0, 6'b100010, 64'h102, 5'd4);
        run_op(1, 6'b100010, 64'h102, 5'd4);
        run_op(0, 6'b101000, 64'h0000_0040, 5'd6);
        run_op(0, 6'b100011, 64'h20, 5'd6);
        run_op(2, 6'b100111, 64'h20, 5'd6);
        poke(0, 64'hFFFF_FFFF_0000_0000, 8);
        run_op(2, 6'b100110, 64'h4, 5'd8);
        run_op(2, 6'b100011, 64'h0, 5'd8);
        run_op(2, 6'b100011, 64'h5, 5'd10);
        run_op(0, 6'b100001, 64'h10, 5'd0);

        // Randomized mix on every configuration
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 40; t++) begin
                cls = $urandom_range(0, 9);
                ra  = {$urandom, $urandom};
                if (cls < 2)       rop = {1'b0, 5'($urandom)};
                else if (cls == 2) rop = {3'b101 + 3'($urandom_range(0, 1)), 3'($urandom)};
                else if (cls == 3) rop = {3'b111, 3'($urandom)};
                else begin
                    rop = {3'b100, 3'($urandom)};
                    ra  = 64'($urandom_range(0, 1023));
                end
                run_op(k, rop, ra, 5'($urandom_range(0, 31)));
            end
        end

        // Reset while waiting on the second beat, then a stray rvalid
        in_valid[0] = 1'b1; opc[0] = 6'b100010; alu[0] = 64'h102; rd[0] = 5'd7;
        tick();
        in_valid[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (req[0] && rv[0]) seen = 1'b1;
            else tick();
        end
        stall[0] = 1'b1;
        check("split_beat0_seen", 64'(seen), 64'd1);
        tick();
        check("req1_active", 64'(req[0]), 64'd1);
        check("req1_addr", daddr[0], 64'h104);
        rst = 1'b1;
        tick();
        check("rst_mid_req", 64'(req[0]), 64'd0);
        check("rst_mid_ready", 64'(in_ready[0]), 64'd0);
        tick();
        late[0] = 1'b1;
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready[0]), 64'd1);
        wes = 0;
        for (int c = 0; c < 4; c++) begin
            if (we[0]) wes++;
            tick();
        end
        late[0] = 1'b0;
        stall[0] = 1'b0;
        repeat (3) begin
            if (we[0]) wes++;
            tick();
        end
        check("late_rvalid_no_we", 64'(wes), 64'd0);
        check("late_rvalid_idle", 64'(in_ready[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_wb_unit.md
Name: load_wb_unit

Overview:
- Parametrised writeback stage; successor to the single-cycle register-file decoder.
- Selects the register-file write value: ALU result, or load data that has been aligned and sign- or zero-extended.
- Adds a valid/ready handshake on its input and a request/response data-memory interface.
- Supports misaligned loads by splitting them into two aligned memory beats. Supports XLEN 32 or 64.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
MISALIGN_EN, 1, 1 = split misaligned loads into two beats; 0 = flag misaligned loads and suppress the write
RF_ADDR_W, 5, register-file address width

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_i  in  1  reset
in_valid_i  in  1  instruction presented
in_ready_o  out  1  unit can accept an instruction
instr_opcode_i  in  6  [5]=0 ALU; [5]=1 with [4:3]: 00 load, 01/10 store/branch, 11 jump/AUIPC/LUI; [2:0]=funct3 for loads
alu_out_i  in  XLEN  ALU result, or effective address for loads
rd_i  in  RF_ADDR_W  destination register
dmem_req_o  out  1  memory read request
dmem_addr_o  out  XLEN  aligned address (low log2(XLEN/8) bits zero)
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
rf_we_o  out  1  register-file write enable, one-cycle pulse
rf_waddr_o  out  RF_ADDR_W  write address
rf_write_o  out  XLEN  write data
misalign_o  out  1  one-cycle pulse: misaligned load when MISALIGN_EN=0
illegal_o  out  1  one-cycle pulse: illegal load funct3

Behaviour:
- Reset:
  - clk_i is the single clock; rst_i is synchronous and active-high.
  - In reset: state=IDLE; rf_we_o, rf_waddr_o, rf_write_o, dmem_req_o, dmem_addr_o, misalign_o, illegal_o all 0; in_ready_o=0 while rst_i is high, 1 in the first cycle after.
  - rst_i asserted mid-load returns the FSM to IDLE and drops dmem_req_o. Any late rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ0, REQ1, WB.
- Handshake:
  - in_ready_o=1 only in IDLE.
  - An instruction is accepted when in_valid_i && in_ready_o. Opcode, rd and address/result are captured on acceptance.
- Non-load (ALU, jump/AUIPC/LUI): IDLE→WB. The next cycle gives rf_we_o=1, rf_write_o=captured alu_out, then →IDLE. Latency 1; throughput 1 per 2 cycles.
- Store/branch: IDLE→WB. rf_we_o stays 0.
- Load:
  - IDLE→REQ0. dmem_req_o=1 with dmem_addr_o = address with low bits cleared, held until dmem_rvalid_i.
  - The response is accepted in the cycle dmem_rvalid_i=1; dmem_req_o drops the next cycle.
  - If offset+size ≤ XLEN/8: extract → WB.
  - Otherwise, with MISALIGN_EN=1: latch the upper bytes of beat 0, go to REQ1, request address+XLEN/8, and on rvalid concatenate the beats, extract, → WB.
  - Otherwise, with MISALIGN_EN=0: WB with rf_we_o=0 and misalign_o=1. No second request is issued.
- funct3 values and widths:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU: legal for all XLEN.
  - 011 LD, 110 LWU: legal only when XLEN=64.
  - Illegal funct3: no memory request, IDLE→WB, rf_we_o=0, illegal_o=1.
  - Signed loads replicate the top loaded bit up to XLEN. Unsigned loads zero-fill.
- rd_i=0: the whole flow runs, but rf_we_o is forced to 0.
- WB lasts exactly one cycle. rf_write_o and rf_waddr_o hold their last value afterwards; only rf_we_o qualifies them.
- dmem_rvalid_i outside REQ0/REQ1 is ignored.

Decomposition:
- Package load_wb_pkg holds:
  - opcode class constants (OPC_ALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JUMP);
  - funct3 constants (F3_LB … F3_LWU);
  - FSM state enum;
  - a function for access size in bytes from funct3.
- Sub-module load_extract: combinational. Takes a 2*XLEN data window, byte offset and funct3; returns the shifted, sign- or zero-extended XLEN value and a legal flag. It is shared by the aligned and split paths.

Test Plan (XLEN=32 unless noted):
- ALU op, alu_out=0xDEADBEEF, rd=5 → one cycle after accept: rf_we_o=1, rf_waddr_o=5, rf_write_o=0xDEADBEEF; in_ready_o low for exactly 1 cycle.
- LB at addr 0x103, rdata=0x80FF1234 returned 2 cycles after req → dmem_addr_o=0x100, rf_write_o=0xFFFFFF80. LBU at the same address gives 0x00000080.
- LW at 0x102, MISALIGN_EN=1; beat 0 from 0x100 = 0xAABB1122, beat 1 from 0x104 = 0x33445566 → two requests, rf_write_o=0x5566AABB. With MISALIGN_EN=0 → one request, misalign_o=1, rf_we_o=0.
- Store opcode, then funct3=011 load → rf_we_o never asserted; illegal_o=1 for the load; no dmem_req_o.
- XLEN=64: LWU at 0x4, rdata=0xFFFFFFFF_00000000 → rf_write_o=0x00000000_FFFFFFFF. LD at 0x0 returns the full word.
- rst_i asserted during REQ1, then rvalid arrives → no rf_we_o; state IDLE; in_ready_o=1 the cycle after rst_i falls. LH with rd=0 → rf_we_o stays 0.
